// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder/subtractor, one CHUNK-bit slice per register stage; latency WIDTH/CHUNK cycles.
// The whole pipe advances only when the output slot is empty or being taken, so in_ready drops while a result waits.
module pipelined_rca_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  // Each stage word rotates right by one slice: the consumed operand slice drops
  // off the bottom and its sum slice enters at the top, so after the last stage
  // the word is the full aligned sum and every result bit leaves together.
  logic [WIDTH-1:0]  x_q   [STAGES];
  logic [WIDTH-1:0]  y_q   [STAGES];
  logic [WIDTH-1:0]  src_x [STAGES];
  logic [WIDTH-1:0]  src_y [STAGES];
  logic [WIDTH-1:0]  nx    [STAGES];
  logic [WIDTH-1:0]  ny    [STAGES];
  logic [CHUNK:0]    rs    [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] src_c;
  logic              ovf_q;
  logic              ovf_d;
  logic              adv;

  function automatic logic [CHUNK:0] ripple(input logic [CHUNK-1:0] xa,
                                            input logic [CHUNK-1:0] xb,
                                            input logic             ci);
    logic             c;
    logic [CHUNK-1:0] s;
    c = ci;
    s = '0;
    for (int i = 0; i < CHUNK; i++) begin
      s[i] = xa[i] ^ xb[i] ^ c;
      c    = (xa[i] & xb[i]) | (c & (xa[i] ^ xb[i]));
    end
    return {c, s};
  endfunction

  // Subtraction is a + ~b + ~cin on the same carry chain.
  always_comb begin
    src_x[0] = a;
    src_y[0] = sub ? ~b : b;
    src_c[0] = cin ^ sub;
    for (int k = 1; k < STAGES; k++) begin
      src_x[k] = x_q[k-1];
      src_y[k] = y_q[k-1];
      src_c[k] = c_q[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      rs[k] = ripple(src_x[k][CHUNK-1:0], src_y[k][CHUNK-1:0], src_c[k]);
      nx[k] = (src_x[k] >> CHUNK) | (WIDTH'(rs[k][CHUNK-1:0]) << (WIDTH - CHUNK));
      ny[k] = src_y[k] >> CHUNK;
    end
    // Operand sign bits are still at the bottom of the last stage's input word.
    ovf_d = (src_x[STAGES-1][CHUNK-1] == src_y[STAGES-1][CHUNK-1]) &&
            (nx[STAGES-1][WIDTH-1] != src_x[STAGES-1][CHUNK-1]);
  end

  assign adv = ~vld_q[STAGES-1] | out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        x_q[k] <= nx[k];
        y_q[k] <= ny[k];
        c_q[k] <= rs[k][CHUNK];
      end
      ovf_q <= ovf_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES-1];
  assign sum       = x_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Drives 16/4, 32/8 and 8/8 adders from shared stimulus; each result is checked against an arithmetic model.
module tb_pipelined_rca_adder;

  logic        clk = 1'b0;
  logic        rst, in_valid, cin, sub, out_ready;
  logic [31:0] a, b;
  logic        ir0, ir1, ir2, ov0, ov1, ov2, co0, co1, co2, of0, of1, of2;
  logic [15:0] s0;
  logic [31:0] s1;
  logic [7:0]  s2;

  always #5 clk = ~clk;

  pipelined_rca_adder #(.WIDTH(16), .CHUNK(4)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .a(a[15:0]), .b(b[15:0]),
    .cin(cin), .sub(sub), .out_valid(ov0), .out_ready(out_ready), .sum(s0), .cout(co0), .ovf(of0));
  pipelined_rca_adder #(.WIDTH(32), .CHUNK(8)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov1), .out_ready(1'b1), .sum(s1), .cout(co1), .ovf(of1));
  pipelined_rca_adder #(.WIDTH(8), .CHUNK(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .a(a[7:0]), .b(b[7:0]),
    .cin(cin), .sub(sub), .out_valid(ov2), .out_ready(1'b1), .sum(s2), .cout(co2), .ovf(of2));

  int          wid [3] = '{16, 32, 8};
  int          stg [3] = '{4, 4, 1};
  logic [33:0] exp_mem [3][1024];
  int          acc_cyc [3][1024];
  int          acc_n [3] = '{0, 0, 0};
  int          rel_n [3] = '{0, 0, 0};
  int          n_assert = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          stall_cnt = 0;
  bit          check_lat = 1'b0;
  bit          was_stall = 1'b0;
  logic [33:0] held;

  // Directed cases for the 16/4 instance: {ovf, cout, sum}
  logic [15:0] da [6] = '{16'd65500, 16'd65500, 16'd6000, 16'd35, 16'h7FFF, 16'h8000};
  logic [15:0] db [6] = '{16'd35, 16'd35, 16'd35, 16'd6500, 16'd1, 16'd1};
  logic        dc [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic        ds [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [17:0] dexp [6] = '{{2'b00, 16'd65535}, {2'b01, 16'd0}, {2'b01, 16'd5965},
                            {2'b00, 16'd59070}, {2'b10, 16'h8000}, {2'b11, 16'h7FFF}};

  function automatic logic [33:0] model(input int w, input logic [31:0] xa, input logic [31:0] xb,
                                        input logic xc, input logic xs);
    longint m, half, ua, ub, c, full, sa, sb, r;
    logic   ov;
    m    = 64'sd1 <<< w;
    half = m >>> 1;
    ua   = longint'(xa) & (m - 64'sd1);
    ub   = longint'(xb) & (m - 64'sd1);
    c    = xc ? 64'sd1 : 64'sd0;
    full = xs ? ua - ub - c + m : ua + ub + c;
    sa   = (ua >= half) ? ua - m : ua;
    sb   = (ub >= half) ? ub - m : ub;
    r    = xs ? sa - sb - c : sa + sb + c;
    ov   = (r >= half) || (r < -half);
    return {ov, full[w], 32'(full & (m - 64'sd1))};
  endfunction

  function automatic logic [33:0] res_of(input int d);
    case (d)
      0:       return {of0, co0, 16'h0, s0};
      1:       return {of1, co1, s1};
      default: return {of2, co2, 24'h0, s2};
    endcase
  endfunction

  function automatic logic ovld(input int d);
    return (d == 0) ? ov0 : (d == 1) ? ov1 : ov2;
  endfunction

  function automatic logic irdy(input int d);
    return (d == 0) ? ir0 : (d == 1) ? ir1 : ir2;
  endfunction

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Scoreboard: release before accept, since no op can leave in the cycle it enters.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      for (int d = 0; d < 3; d++) rel_n[d] = acc_n[d];
      was_stall = 1'b0;
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (ovld(d) && (d != 0 || out_ready)) begin
          check($sformatf("unexpected_result_d%0d", d), 34'(rel_n[d] < acc_n[d]), 34'd1);
          if (rel_n[d] < acc_n[d]) begin
            check($sformatf("result_d%0d_op%0d", d, rel_n[d]), res_of(d), exp_mem[d][rel_n[d] % 1024]);
            if (check_lat)
              check($sformatf("latency_d%0d_op%0d", d, rel_n[d]),
                    34'(cyc - acc_cyc[d][rel_n[d] % 1024]), 34'(stg[d]));
            rel_n[d]++;
          end
        end
        if (in_valid && irdy(d)) begin
          exp_mem[d][acc_n[d] % 1024] = model(wid[d], a, b, cin, sub);
          acc_cyc[d][acc_n[d] % 1024] = cyc;
          acc_n[d]++;
        end
      end
      check("in_ready_rule", 34'(ir0), 34'(!ov0 || out_ready));
      if (was_stall) check("stall_hold", res_of(0), held);
      was_stall = ov0 && !out_ready;
      if (was_stall) stall_cnt++;
      held = res_of(0);
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input logic [31:0] xa, input logic [31:0] xb, input logic xc, input logic xs);
    int t;
    a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!ir0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("push_timeout", 34'(t < 100), 34'd1);
    sync();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((rel_n[0] != acc_n[0] || rel_n[1] != acc_n[1] || rel_n[2] != acc_n[2]) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_all_delivered", 34'(t < 200), 34'd1);
    sync();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (2) sync();
    check("reset_state_16", {of0, co0, 16'h0, s0, 15'h0, ov0}, 34'd0);
    check("reset_state_32_8", {ov1, s1, ov2}, 34'd0);
    rst = 1'b0;
    sync();
    check("in_ready_after_reset", 34'(ir0), 34'd1);

    // Directed arithmetic and boundary cases, one at a time.
    check_lat = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_op({16'h0, da[i]}, {16'h0, db[i]}, dc[i], ds[i]);
      k = 1;
      @(negedge clk);
      while (!ov0 && k < 20) begin
        @(negedge clk);
        k++;
      end
      check($sformatf("directed_latency_%0d", i), 34'(k), 34'd4);
      check($sformatf("directed_result_%0d", i), {16'h0, of0, co0, s0}, {16'h0, dexp[i]});
      sync();
    end
    drain();

    // Back-to-back stream of 8 ops, out_ready held high.
    for (int i = 0; i < 8; i++) push_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drain();
    check_lat = 1'b0;

    // Backpressure: out_ready low for 5 cycles while ops keep arriving.
    fork
      for (int i = 0; i < 10; i++) push_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      begin
        repeat (3) sync();
        out_ready = 1'b0;
        repeat (5) sync();
        out_ready = 1'b1;
      end
    join
    drain();
    check("stall_observed", 34'(stall_cnt >= 3), 34'd1);

    // Reset with three ops in flight: none of them may ever come out.
    for (int i = 0; i < 3; i++) push_op($urandom, $urandom, 1'b0, 1'($urandom_range(0, 1)));
    rst = 1'b1;
    sync();
    check("mid_reset_clear_16", {16'h0, ov0, 1'b0, s0}, 34'd0);
    check("mid_reset_clear_32_8", {1'b0, ov1, ov2, 31'h0}, 34'd0);
    rst = 1'b0;
    sync();
    check("in_ready_after_mid_reset", 34'(ir0), 34'd1);
    repeat (10) sync();
    for (int d = 0; d < 3; d++)
      check($sformatf("no_ghost_results_d%0d", d), 34'(acc_n[d] - rel_n[d]), 34'd0);

    // Random traffic with bubbles and random backpressure.
    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 2)) sync();
        push_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (150) begin
          sync();
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
